// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter that serialises commands from requesters A and B onto a single-port
// register file, routes read data back to the issuer and closes reads that never return.
module reg_file_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  A_Req,
    input  logic                  A_Wr,
    input  logic [ADDR_WIDTH-1:0] A_Addr,
    input  logic [DATA_WIDTH-1:0] A_WrData,
    input  logic                  B_Req,
    input  logic                  B_Wr,
    input  logic [ADDR_WIDTH-1:0] B_Addr,
    input  logic [DATA_WIDTH-1:0] B_WrData,
    output logic                  A_Ack,
    output logic [DATA_WIDTH-1:0] A_RdData,
    output logic                  A_RdData_Valid,
    output logic                  A_Err,
    output logic                  B_Ack,
    output logic [DATA_WIDTH-1:0] B_RdData,
    output logic                  B_RdData_Valid,
    output logic                  B_Err,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    input  logic [DATA_WIDTH-1:0] RF_RdData,
    input  logic                  RF_RdData_Valid
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;   // 1: B wins a tie
    logic                  gnt_q, gnt_d;   // 1: B owns the command in flight
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rf_wr_en_q, rf_wr_en_d, rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                  a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic                  a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic                  sel_b, sel_wr, timed_out, rd_done;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata, rd_val;

    always_comb begin
        sel_b     = B_Req && (!A_Req || ptr_q);
        sel_wr    = sel_b ? B_Wr : A_Wr;
        sel_addr  = sel_b ? B_Addr : A_Addr;
        sel_wdata = sel_b ? B_WrData : A_WrData;
        timed_out = !RF_RdData_Valid && (cnt_q == CNT_LAST);
        rd_done   = RF_RdData_Valid || timed_out;
        rd_val    = RF_RdData_Valid ? RF_RdData : '0;

        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        rf_wr_en_d = 1'b0;
        rf_rd_en_d = 1'b0;
        rf_addr_d  = '0;
        rf_wdata_d = '0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_vld_d    = 1'b0;
        b_vld_d    = 1'b0;
        a_err_d    = 1'b0;
        b_err_d    = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;

        // Outputs are computed for the state being entered so every port comes straight from a flop.
        unique case (state_q)
            IDLE: begin
                if (A_Req || B_Req) begin
                    gnt_d     = sel_b;
                    ptr_d     = !sel_b;
                    rf_addr_d = sel_addr;
                    if (sel_wr) begin
                        state_d    = WRITE;
                        rf_wr_en_d = 1'b1;
                        rf_wdata_d = sel_wdata;
                        a_ack_d    = !sel_b;
                        b_ack_d    = sel_b;
                    end else begin
                        state_d    = READ;
                        rf_rd_en_d = 1'b1;
                    end
                end
            end
            WRITE: state_d = IDLE;
            READ: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_done) begin
                    state_d = RESP;
                    if (gnt_q) begin
                        b_rdata_d = rd_val;
                        b_ack_d   = 1'b1;
                        b_vld_d   = 1'b1;
                        b_err_d   = timed_out;
                    end else begin
                        a_rdata_d = rd_val;
                        a_ack_d   = 1'b1;
                        a_vld_d   = 1'b1;
                        a_err_d   = timed_out;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            gnt_q      <= 1'b0;
            cnt_q      <= '0;
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_vld_q    <= 1'b0;
            b_vld_q    <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_rd_en_q <= rf_rd_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_vld_q    <= a_vld_d;
            b_vld_q    <= b_vld_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign RF_WrEn        = rf_wr_en_q;
    assign RF_RdEn        = rf_rd_en_q;
    assign RF_Address     = rf_addr_q;
    assign RF_WrData      = rf_wdata_q;
    assign A_Ack          = a_ack_q;
    assign B_Ack          = b_ack_q;
    assign A_RdData_Valid = a_vld_q;
    assign B_RdData_Valid = b_vld_q;
    assign A_Err          = a_err_q;
    assign B_Err          = b_err_q;
    assign A_RdData       = a_rdata_q;
    assign B_RdData       = b_rdata_q;
endmodule

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Two-requester round-robin arbiter and sequencer that shares the single-port register file between two masters (e.g. system controller and a configuration/debug path). It serialises write and read commands onto the register file's WrEn/RdEn/Address/WrData port, waits for the file's read-valid strobe, and routes read data back to the requester that issued the read. A read that never returns valid is closed by a timeout and flagged as an error.

## Interface
- DATA_WIDTH, 8, register data width (matches register file WIDTH)
- ADDR_WIDTH, 4, register address width (matches register file address port)
- RD_TIMEOUT, 4, max cycles spent in RD_WAIT before aborting a read (>=1)

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous active-low reset
- A_Req, B_Req  in  1  command request, held until matching Ack
- A_Wr, B_Wr  in  1  1 = write, 0 = read; sampled with Req
- A_Addr, B_Addr  in  ADDR_WIDTH  register address
- A_WrData, B_WrData  in  DATA_WIDTH  write data
- A_Ack, B_Ack  out  1  one-cycle pulse: command completed
- A_RdData, B_RdData  out  DATA_WIDTH  read data, held until next read response to that requester
- A_RdData_Valid, B_RdData_Valid  out  1  one-cycle pulse with read Ack
- A_Err, B_Err  out  1  one-cycle pulse with Ack on read timeout
- RF_WrEn, RF_RdEn  out  1  register-file strobes, never both high
- RF_Address  out  ADDR_WIDTH  register-file address
- RF_WrData  out  DATA_WIDTH  register-file write data
- RF_RdData  in  DATA_WIDTH  register-file read data
- RF_RdData_Valid  in  1  register-file read-valid

## Operation
- States: IDLE, WRITE, READ, RD_WAIT, RESP. Reset: IDLE, priority pointer = A, timeout counter 0, every output 0.
- IDLE: if no Req, stay. If exactly one Req, grant it. If both, grant pointer side. Latch grantee's Wr/Addr/WrData and grantee ID; go WRITE if Wr=1 else READ. Pointer := non-granted side on every grant.
- WRITE (1 cycle): RF_WrEn=1, RF_Address/RF_WrData = latched command, grantee Ack=1; -> IDLE.
- READ (1 cycle): RF_RdEn=1, RF_Address = latched address; counter := 0; -> RD_WAIT.
- RD_WAIT: RF_* strobes 0. If RF_RdData_Valid=1: capture RF_RdData, -> RESP (ok). Else counter+1; when counter reaches RD_TIMEOUT-1 without valid: capture 0, -> RESP (err).
- RESP (1 cycle): grantee RdData = captured value, RdData_Valid=1, Ack=1; Err=1 if timed out; -> IDLE. Non-grantee outputs unchanged.
- RF_RdData_Valid ignored in every state except RD_WAIT (register file may hold a stale valid across writes).
- RF_Address/RF_WrData drive 0 when the corresponding strobe is low.
- Req dropped after grant: latched command still completes and Ack still pulses.
- Reset asserted mid-command: command abandoned, state IDLE, all outputs 0 immediately (async); no Ack later.

## Timing
- All outputs registered (state-decoded from flops); no combinational path Req -> Ack or Req -> RF_*.
- Write: Req seen in IDLE cycle N -> RF_WrEn and Ack high cycle N+1 -> IDLE N+2. Max 1 write per 2 cycles.
- Read: Req cycle N -> RF_RdEn cycle N+1 -> RF_RdData_Valid expected cycle N+2 -> Ack/RdData_Valid cycle N+3 -> IDLE N+4.
- Timeout read: Ack+Err at cycle N+2+RD_TIMEOUT.
- Requester must not reassert a new command in the Ack cycle's following cycle expecting same-cycle grant; a Req still high in IDLE is treated as a new command.

## Test plan
- Reset: drive RST=0 mid-read -> all outputs 0, state IDLE; after release A_Req write addr 0x5 data 0xA5 -> RF_WrEn cycle N+1 with addr 5, data 0xA5, A_Ack same cycle.
- Read path with register-file model: B reads addr 2 (reset value 0x81) -> RF_RdEn N+1, B_RdData=0x81, B_RdData_Valid and B_Ack at N+3, A outputs untouched.
- Contention: A and B both hold write Req continuously -> grants alternate A,B,A,B starting A; each Ack every 4 cycles per requester.
- Write then read of same address by different requesters: A writes 0x3C to addr 7, B reads addr 7 -> B_RdData=0x3C; stale RF_RdData_Valid held high during write does not produce a spurious response.
- Timeout: model never asserts RF_RdData_Valid, RD_TIMEOUT=4 -> A_Ack, A_Err, A_RdData_Valid at N+6, A_RdData=0.
- Req dropped one cycle after grant on read -> read still issued, Ack pulses at N+3; RF_WrEn and RF_RdEn never high together throughout.
